// File: rtl/execute_unit_pkg.sv
// Shared definitions for the execute stage: opcodes, flag bit positions and FSM encoding.
package execute_unit_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic is_shift(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/execute_unit_alu.sv
// Single-cycle ADD/SUB/AND/OR/XOR with carry and signed-overflow outputs.
module alu_core
    import execute_unit_pkg::*;
#(
    parameter int L = DATA_W
) (
    input  logic [2:0]   op_i,
    input  logic [L-1:0] a_i,
    input  logic [L-1:0] b_i,
    output logic [L-1:0] res_o,
    output logic         c_o,
    output logic         v_o
);

    logic         sub;
    logic [L-1:0] b_eff;
    logic [L:0]   sum;

    always_comb begin
        sub   = (op_e'(op_i) == OP_SUB);
        // Subtraction is a + ~b + 1, so carry out of 1 means no borrow.
        b_eff = sub ? ~b_i : b_i;
        sum   = {1'b0, a_i} + {1'b0, b_eff} + {{L{1'b0}}, sub};
        res_o = '0;
        c_o   = 1'b0;
        v_o   = 1'b0;
        case (op_e'(op_i))
            OP_ADD, OP_SUB: begin
                res_o = sum[L-1:0];
                c_o   = sum[L];
                v_o   = (a_i[L-1] == b_eff[L-1]) && (sum[L-1] != a_i[L-1]);
            end
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// Multi-cycle execute stage driving the register file; refresh-writes port A when idle.
//   state   | meaning
//   IDLE    | addresses follow SrcB/SrcC, waiting for Start
//   ITER    | one shift bit or one multiply step per cycle
//   WB      | result written to Dest, flags updated, Done pulses
module execute_unit
    import execute_unit_pkg::*;
#(
    parameter int L = DATA_W,
    parameter int A = ADDR_W
) (
    input  logic         Clk_i,
    input  logic         Reset_i,
    input  logic         Start_i,
    input  logic [2:0]   Op_i,
    input  logic [A-1:0] SrcB_i,
    input  logic [A-1:0] SrcC_i,
    input  logic [A-1:0] Dest_i,
    output logic [A-1:0] AddrA_o,
    output logic [A-1:0] AddrB_o,
    output logic [A-1:0] AddrC_o,
    input  logic [L-1:0] DataB_i,
    input  logic [L-1:0] DataC_i,
    output logic [L-1:0] InDataA_o,
    output logic [L-1:0] InNewFlags_o,
    output logic         UpdateFlags_o,
    output logic         Busy_o,
    output logic         Done_o
);

    localparam int SH_W  = $clog2(L);
    localparam int CNT_W = SH_W + 1;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [A-1:0]     dest_q, dest_d;
    logic [A-1:0]     srcb_q, srcb_d;
    logic [A-1:0]     srcc_q, srcc_d;
    logic [L-1:0]     opb_q, opb_d;
    logic [L-1:0]     opc_q, opc_d;
    logic [2*L-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shc_q, shc_d;

    logic [L:0]       hi_sum;
    logic [L-1:0]     alu_res, res;
    logic             alu_c, alu_v, c_flag, v_flag, wb;
    logic [L-1:0]     flags;

    alu_core #(.L(L)) u_alu (
        .op_i  (op_q),
        .a_i   (opb_q),
        .b_i   (opc_q),
        .res_o (alu_res),
        .c_o   (alu_c),
        .v_o   (alu_v)
    );

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            dest_q  <= '0;
            srcb_q  <= '0;
            srcc_q  <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            shc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            srcb_q  <= srcb_d;
            srcc_q  <= srcc_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            shc_q   <= shc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dest_d  = dest_q;
        srcb_d  = srcb_q;
        srcc_d  = srcc_q;
        opb_d   = opb_q;
        opc_d   = opc_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        shc_d   = shc_q;
        // Multiply step: add multiplicand into the high half when the current opC bit is set.
        hi_sum  = {1'b0, acc_q[2*L-1:L]} + (acc_q[0] ? {1'b0, opb_q} : '0);

        unique case (state_q)
            ST_IDLE: begin
                if (Start_i) begin
                    op_d   = op_e'(Op_i);
                    dest_d = Dest_i;
                    srcb_d = SrcB_i;
                    srcc_d = SrcC_i;
                    opb_d  = DataB_i;
                    opc_d  = DataC_i;
                    acc_d  = {{L{1'b0}}, DataC_i};
                    shc_d  = 1'b0;
                    if (op_e'(Op_i) == OP_MUL) begin
                        cnt_d   = CNT_W'(L);
                        state_d = ST_ITER;
                    end else if (is_shift(op_e'(Op_i)) && (DataC_i[SH_W-1:0] != '0)) begin
                        cnt_d   = {1'b0, DataC_i[SH_W-1:0]};
                        state_d = ST_ITER;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_ITER: begin
                cnt_d = cnt_q - CNT_W'(1);
                case (op_q)
                    OP_SHL: begin
                        shc_d = opb_q[L-1];
                        opb_d = {opb_q[L-2:0], 1'b0};
                    end
                    OP_SHR: begin
                        shc_d = opb_q[0];
                        opb_d = {1'b0, opb_q[L-1:1]};
                    end
                    default: acc_d = {hi_sum, acc_q[L-1:1]};
                endcase
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_WB;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        res    = alu_res;
        c_flag = alu_c;
        v_flag = alu_v;
        case (op_q)
            OP_SHL, OP_SHR: begin
                res    = opb_q;
                c_flag = shc_q;
                v_flag = 1'b0;
            end
            OP_MUL: begin
                res    = acc_q[L-1:0];
                c_flag = 1'b0;
                v_flag = |acc_q[2*L-1:L];
            end
            default: ;
        endcase
        flags         = '0;
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_N] = res[L-1];
        flags[FLAG_C] = c_flag;
        flags[FLAG_V] = v_flag;
    end

    // Outside write-back (and throughout reset) port A rewrites the port-B register with itself.
    always_comb begin
        wb            = (state_q == ST_WB) && !Reset_i;
        AddrB_o       = (state_q == ST_IDLE) ? SrcB_i : srcb_q;
        AddrC_o       = (state_q == ST_IDLE) ? SrcC_i : srcc_q;
        AddrA_o       = wb ? dest_q : AddrB_o;
        InDataA_o     = wb ? res : DataB_i;
        InNewFlags_o  = wb ? flags : '0;
        UpdateFlags_o = wb && (dest_q != {A{1'b1}});
        Done_o        = wb;
        Busy_o        = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: register-file model, arithmetic reference model and per-cycle compare.
module tb_execute_unit;

    localparam int L = 16;
    localparam int A = 3;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [2:0]   Op = '0;
    logic [A-1:0] SrcB = '0, SrcC = '0, Dest = '0;
    logic [A-1:0] AddrA, AddrB, AddrC;
    logic [L-1:0] DataB, DataC, InDataA, InNewFlags;
    logic         UpdateFlags, Busy, Done;

    logic [L-1:0] rf [8];
    logic         ld_en = 1'b0;
    logic [A-1:0] ld_addr = '0;
    logic [L-1:0] ld_data = '0;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    execute_unit dut (
        .Clk_i         (Clk),
        .Reset_i       (Reset),
        .Start_i       (Start),
        .Op_i          (Op),
        .SrcB_i        (SrcB),
        .SrcC_i        (SrcC),
        .Dest_i        (Dest),
        .AddrA_o       (AddrA),
        .AddrB_o       (AddrB),
        .AddrC_o       (AddrC),
        .DataB_i       (DataB),
        .DataC_i       (DataC),
        .InDataA_o     (InDataA),
        .InNewFlags_o  (InNewFlags),
        .UpdateFlags_o (UpdateFlags),
        .Busy_o        (Busy),
        .Done_o        (Done)
    );

    // Register file: port A written every clock, flags register on UpdateFlags, bench load last.
    assign DataB = rf[AddrB];
    assign DataC = rf[AddrC];
    always @(posedge Clk) begin
        rf[AddrA] <= InDataA;
        if (UpdateFlags) rf[7] <= InNewFlags;
        if (ld_en) rf[ld_addr] <= ld_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: result, flags word and number of iteration cycles from plain arithmetic.
    function automatic void ref_exec(input int op, input int b, input int c,
                                     output int res, output int fl, output int iters);
        longint r;
        int sb, sc, s, n, cf, vf;
        sb = (b >= 32768) ? b - 65536 : b;
        sc = (c >= 32768) ? c - 65536 : c;
        n = c % 16;
        cf = 0; vf = 0; iters = 0; res = 0;
        case (op)
            0: begin
                r = longint'(b) + longint'(c);
                res = int'(r % 65536); cf = int'(r / 65536);
                s = sb + sc; vf = (s > 32767 || s < -32768) ? 1 : 0;
            end
            1: begin
                r = longint'(b) + longint'(65535 - c) + 1;
                res = int'(r % 65536); cf = int'(r / 65536);
                s = sb - sc; vf = (s > 32767 || s < -32768) ? 1 : 0;
            end
            2: res = b & c;
            3: res = b | c;
            4: res = b ^ c;
            5: begin
                res = (b << n) % 65536;
                cf = (n == 0) ? 0 : (b >> (16 - n)) % 2;
                iters = n;
            end
            6: begin
                res = b >> n;
                cf = (n == 0) ? 0 : (b >> (n - 1)) % 2;
                iters = n;
            end
            default: begin
                r = longint'(b) * longint'(c);
                res = int'(r % 65536);
                vf = (r >= 65536) ? 1 : 0;
                iters = 16;
            end
        endcase
        fl = ((res == 0) ? 1 : 0) + ((res >= 32768) ? 2 : 0) + ((cf != 0) ? 4 : 0) + ((vf != 0) ? 8 : 0);
    endfunction

    bit           m_busy = 1'b0, m_wb = 1'b0;
    int           m_left = 0, m_res = 0, m_fl = 0;
    logic [A-1:0] m_dest = '0, m_srcb = '0, m_srcc = '0;

    // Compare at negedge against the model, then advance the model for the coming edge.
    always @(negedge Clk) begin
        logic [A-1:0] eb, ec;
        int it;
        eb = m_busy ? m_srcb : SrcB;
        ec = m_busy ? m_srcc : SrcC;
        if (chk_en) begin
            check("busy", Busy, m_busy);
            check("done", Done, m_wb && !Reset);
            check("addr_b", AddrB, eb);
            check("addr_c", AddrC, ec);
            if (m_wb && !Reset) begin
                check("wb_addr", AddrA, m_dest);
                check("wb_data", InDataA, m_res);
                check("wb_flags", InNewFlags, m_fl);
                check("wb_upd", UpdateFlags, m_dest != 3'd7);
            end else begin
                check("ref_addr", AddrA, eb);
                check("ref_data", InDataA, rf[eb]);
                check("ref_upd", UpdateFlags, 0);
            end
        end
        if (Reset) begin
            m_busy = 1'b0; m_wb = 1'b0; m_left = 0;
        end else if (!m_busy) begin
            if (Start) begin
                ref_exec(int'(Op), int'(rf[SrcB]), int'(rf[SrcC]), m_res, m_fl, it);
                m_busy = 1'b1; m_dest = Dest; m_srcb = SrcB; m_srcc = SrcC;
                m_left = it; m_wb = (it == 0);
            end
        end else if (m_wb) begin
            m_busy = 1'b0; m_wb = 1'b0;
        end else begin
            m_left--;
            if (m_left == 0) m_wb = 1'b1;
        end
    end

    // All tasks below start and end just after a rising edge.
    task automatic set_reg(input int a, input int v);
        ld_en = 1'b1; ld_addr = A'(a); ld_data = L'(v);
        @(posedge Clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic run_op(input int op, input int sb, input int sc, input int d,
                          input int poke_at, input int rst_at,
                          output int lat, output int bcnt, output logic upd);
        Op = 3'(op); SrcB = A'(sb); SrcC = A'(sc); Dest = A'(d); Start = 1'b1;
        lat = 0; bcnt = 0; upd = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clk); #1;
            Start = (k == poke_at);
            if (k == poke_at) Op = 3'd0;
            Reset = (k == rst_at);
            if (Busy) bcnt++;
            if (Done) begin
                lat = k; upd = UpdateFlags;
            end
            if (Done || (rst_at > 0 && k > rst_at + 2)) break;
        end
        Start = 1'b0; Reset = 1'b0;
        if (lat > 0) begin
            @(posedge Clk); #1;
        end else if (rst_at == 0) begin
            check("done_timeout", lat, 1);
        end
    endtask

    initial begin
        int lat, bcnt;
        logic upd;
        logic [L-1:0] snap [8];

        repeat (2) @(posedge Clk);
        #1;
        chk_en = 1'b1;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_upd", UpdateFlags, 0);
        for (int i = 0; i < 8; i++) set_reg(i, 0);
        Reset = 1'b0;

        set_reg(1, 5); set_reg(2, 7);
        run_op(0, 1, 2, 3, 0, 0, lat, bcnt, upd);
        check("add_lat", lat, 1);
        check("add_r3", rf[3], 12);
        check("add_flags", rf[7], 16'h0000);
        check("add_r1", rf[1], 5);
        check("add_r2", rf[2], 7);

        set_reg(1, 16'h7FFF); set_reg(2, 1);
        run_op(0, 1, 2, 3, 0, 0, lat, bcnt, upd);
        check("addv_r3", rf[3], 16'h8000);
        check("addv_flags", rf[7], 16'h000A);

        set_reg(4, 5);
        run_op(1, 4, 4, 5, 0, 0, lat, bcnt, upd);
        check("sub_r5", rf[5], 0);
        check("sub_flags", rf[7], 16'h0005);

        set_reg(1, 16'h8001); set_reg(2, 3);
        run_op(5, 1, 2, 3, 0, 0, lat, bcnt, upd);
        check("shl_lat", lat, 4);
        check("shl_r3", rf[3], 16'h0008);
        check("shl_flags", rf[7], 16'h0000);
        run_op(6, 1, 2, 3, 0, 0, lat, bcnt, upd);
        check("shr_lat", lat, 4);
        check("shr_r3", rf[3], 16'h1000);
        check("shr_flags", rf[7], 16'h0000);

        set_reg(6, 0);
        run_op(5, 1, 6, 3, 0, 0, lat, bcnt, upd);
        check("sh0_lat", lat, 1);
        check("sh0_r3", rf[3], 16'h8001);
        check("sh0_flags", rf[7], 16'h0002);

        run_op(2, 1, 2, 5, 0, 0, lat, bcnt, upd);
        run_op(3, 1, 2, 6, 0, 0, lat, bcnt, upd);
        check("b2b_lat", lat, 1);
        run_op(4, 1, 2, 4, 0, 0, lat, bcnt, upd);
        check("and_r5", rf[5], 16'h0001);
        check("or_r6", rf[6], 16'h8003);
        check("xor_r4", rf[4], 16'h8002);

        set_reg(1, 300); set_reg(2, 300);
        run_op(7, 1, 2, 3, 5, 0, lat, bcnt, upd);
        check("mul_lat", lat, 17);
        check("mul_busy", bcnt, 17);
        check("mul_r3", rf[3], 16'h5F90);
        check("mul_flags", rf[7], 16'h0008);

        run_op(0, 3, 3, 1, 0, 0, lat, bcnt, upd);
        check("raw_r1", rf[1], 16'hBF20);
        check("raw_flags", rf[7], 16'h000A);

        run_op(0, 2, 2, 7, 0, 0, lat, bcnt, upd);
        check("d7_upd", upd, 0);
        check("d7_r7", rf[7], 16'h0258);

        run_op(7, 2, 2, 4, 0, 5, lat, bcnt, upd);
        check("rst_nodone", lat, 0);
        check("rst_r4", rf[4], 16'h8002);
        check("rst_idle", Busy, 0);

        for (int i = 0; i < 8; i++) snap[i] = rf[i];
        for (int i = 0; i < 10; i++) begin
            SrcB = A'($urandom_range(0, 7));
            SrcC = A'($urandom_range(0, 7));
            @(posedge Clk); #1;
        end
        for (int i = 0; i < 8; i++) check("idle_keep", rf[i], snap[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- Multi-cycle execute stage directly upstream of the register file.
- Drives all three register-file address ports. Reads operands through ports B and C, and computes an ALU, shift or multiply result.
- Writes the result back through port A and the flags word through the flags-update path.
- The register file writes port A on every clock with no enable, so on non-result cycles this block issues a refresh write: AddrA = AddrB, InDataA = OutDataB.

Parameters:
- l, 16, data/register width.
- a, 3, register address width; the flags register is at address 2^a-1.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request pulse; accepted only in IDLE.
- Op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL.
- SrcB  in  a  first operand register address.
- SrcC  in  a  second operand register address.
- Dest  in  a  destination register address.
- AddrA  out  a  to register file AddrA.
- AddrB  out  a  to register file AddrB.
- AddrC  out  a  to register file AddrC.
- DataB  in  l  from register file OutDataB.
- DataC  in  l  from register file OutDataC.
- InDataA  out  l  to register file InDataA.
- InNewFlags  out  l  to register file InNewFlags.
- UpdateFlags  out  1  to register file UpdateFlags.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse in the write-back cycle.

Behaviour:
- States and transitions:
  - IDLE: on Start, go to ITER if Op is SHL/SHR with DataC[3:0]≠0, or if Op is MUL; otherwise go to WB.
  - ITER: go to WB when the iteration counter reaches 0.
  - WB: always go to IDLE.
- Acceptance in IDLE:
  - AddrB = SrcB and AddrC = SrcC, combinationally.
  - On the Start edge, latch Op, Dest, opB = DataB, opC = DataC.
- Addressing after acceptance: AddrB and AddrC hold the latched SrcB/SrcC until back in IDLE.
- Refresh writes: in IDLE, ITER and during Reset, AddrA = AddrB, InDataA = DataB, UpdateFlags = 0.
- WB cycle outputs: AddrA = Dest, InDataA = result, InNewFlags = flags, UpdateFlags = 1 (but 0 when Dest = 2^a-1, so the result wins), Done = 1.
- Latency, counting Start as cycle 0:
  - ADD/SUB/logic, and shifts with amount 0: WB in cycle 1.
  - Shifts with amount n: WB in cycle n+1, one bit per ITER cycle.
  - MUL: 16 ITER cycles, WB in cycle 17.
- MUL datapath:
  - Unsigned shift-add over opC bits LSB first into a 2l-bit accumulator.
  - Result is the low l bits.
- Flags word: bit0 Z (result==0), bit1 N (result[l-1]), bit2 C, bit3 V; all other bits 0.
- C and V by operation:
  - ADD: C = carry out, V = signed overflow.
  - SUB: computed as opB + ~opC + 1; C = carry out (1 means no borrow), V = signed overflow.
  - AND/OR/XOR: C = 0, V = 0.
  - SHL/SHR: C = last bit shifted out (0 if amount is 0), V = 0.
  - MUL: C = 0, V = |high l bits.
- Start while Busy is ignored; there is no queueing.
- Reset:
  - State goes to IDLE; opB, opC, accumulator, counter, Busy, Done and UpdateFlags clear to 0.
  - Reset mid-operation aborts with no result write.
- After WB, the block returns to IDLE. A Start in the first IDLE cycle is accepted, so back-to-back ops run with a 1-cycle gap.
- Read-after-write: the register file updates on the WB edge, so the next accepted op reads the new value.

Decomposition:
- Shared package: opcode constants, flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3), FSM state encoding.
- Sub-module: alu_core, a combinational ADD/SUB/AND/OR/XOR producing result, C and V. The shift/multiply iteration stays in execute_unit.

Test Plan:
- R1=5, R2=7; ADD Dest=3, SrcB=1, SrcC=2 → WB in cycle 1, R3=12, flags=0x0000, R1 and R2 unchanged.
- R1=0x7FFF, R2=1; ADD → R3=0x8000, flags=0x000A (N, V). SUB of 5-5 → 0, flags=0x0005 (Z, C).
- R1=0x8001, R2=3; SHL → WB in cycle 4, result 0x0008, C=0. SHR → 0x1000, C=0. Shift amount 0 → WB in cycle 1, result unchanged, C=0.
- R1=300, R2=300; MUL → Busy for 17 cycles, Done in cycle 17, result 0x5F90, V=1. A Start mid-operation is ignored.
- ADD with Dest=7 → R7 = result, UpdateFlags=0. Reset asserted in cycle 5 of a MUL → Dest unchanged, Done never pulses.
- Idle for 10 cycles with arbitrary SrcB → all registers keep their values.
